mem_bank_responder: RTL
=======================

MEM_BANK_RESPONDER -- requirements
Module: mem_bank_responder

Interface
REQ-001 SHALL have parameter BANK_DEPTH, default 8192: 16-bit words per bank.
REQ-002 SHALL have parameter RD_LAT, default 2: cycles from accepted read to rd_valid.
REQ-003 SHALL have parameter BANK_BUSY, default 4: cycles a bank is occupied per accepted access, including the accept cycle.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port rd, input, 1 bit: read request.
REQ-007 SHALL have port wr, input, 1 bit: write request.
REQ-008 SHALL have port addr, input, 16 bits: byte address.
REQ-009 SHALL have port data_in, input, 16 bits: write data.
REQ-010 SHALL have port data_out, output, 16 bits: read data, meaningful only while rd_valid=1.
REQ-011 SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking data_out valid.
REQ-012 SHALL have port stall, output, 1 bit: request not accepted this cycle; combinational.
REQ-013 SHALL have port busy, output, 4 bits: per-bank occupied flags.
REQ-014 SHALL have port err, output, 1 bit: registered error pulse.

Function
REQ-015 SHALL select bank = addr[2:1] and row = addr[15:3] modulo BANK_DEPTH.
REQ-016 SHALL assert stall combinationally when (rd|wr)=1 and busy[bank]=1; a stalled request SHALL have no effect, and the initiator holds it.
REQ-017 SHALL accept a request when (rd|wr)=1 and stall=0.
REQ-018 On an accepted write, storage SHALL update at the accept edge.
REQ-019 On an accepted read, storage SHALL be read at accept; rd_valid SHALL pulse exactly RD_LAT cycles later with that data.
REQ-020 data_out SHALL hold its last value when rd_valid=0.
REQ-021 On accept, busy[bank] SHALL be set for BANK_BUSY cycles; the earliest next accept to the same bank is accept+BANK_BUSY.
REQ-022 Different banks SHALL accept on consecutive cycles, one request per cycle.
REQ-023 Up to RD_LAT reads SHALL be in flight, and they SHALL return in accept order.
REQ-024 A read after a write to the same address SHALL return the new data.

Reset
REQ-025 While rst=0: busy=0, rd_valid=0, data_out=0, err=0, and all in-flight reads are discarded, including mid-operation.
REQ-026 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With MEM_RESP_ERR_CHECK_EN defined, the following requests SHALL be rejected without access: addr[0]=1, or rd&wr=1 on a non-stalled cycle. A rejected request SHALL set no busy flag, and err SHALL pulse for 1 cycle on the next edge.
REQ-028 Without MEM_RESP_ERR_CHECK_EN: addr[0] is ignored, rd&wr=1 is treated as a write, and err is tied 0.

Structure
REQ-029 Package mem_resp_pkg SHALL hold NUM_BANKS=4, the bank-select bit positions, and the in-flight read-record typedef (valid, bank, data).
REQ-030 Sub-module mem_bank SHALL implement one bank: storage array plus busy down-counter. It SHALL be instantiated NUM_BANKS times.

Verification
REQ-031 Write 0xBEEF to 0x0010 at t, then read 0x0010 at t+4 -> stall=0 at t and at t+4; rd_valid at t+6 with data_out=0xBEEF.
REQ-032 Read 0x0000 at t, then read 0x0002 at t+1 -> no stall; rd_valid at t+2 and t+3, returning in order.
REQ-033 Read 0x0008 at t, then hold read 0x0000 -> stall=1 at t+1..t+3; accept at t+4; busy[0]=1 during t..t+7.
REQ-034 Assert rst=0 one cycle after a read is accepted -> no rd_valid ever appears; busy=0 immediately; a rewritten location still returns its data after reset.
REQ-035 With MEM_RESP_ERR_CHECK_EN: write to 0x0011 -> err=1 next cycle, busy stays 0, and a read of 0x0010 returns unchanged data.
REQ-036 Without MEM_RESP_ERR_CHECK_EN: rd=wr=1 to 0x0020 with 0x1234 -> written; err=0; a later read returns 0x1234.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared constants and types for the banked memory responder: bank geometry,
// address field positions and the record tracking a read in flight.
package mem_resp_pkg;

    localparam int NUM_BANKS = 4;
    localparam int BANK_W    = 2;
    localparam int BANK_LSB  = 1;
    localparam int BANK_MSB  = 2;
    localparam int ROW_LSB   = 3;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;

    typedef logic [BANK_W-1:0] bank_idx_t;

    typedef struct packed {
        logic              valid;
        bank_idx_t         bank;
        logic [DATA_W-1:0] data;
    } rd_rec_t;

    function automatic logic [NUM_BANKS-1:0] bank_onehot(input bank_idx_t b);
        bank_onehot = NUM_BANKS'(1) << b;
    endfunction

endpackage

// File: rtl/mem_bank.sv
// One memory bank: word storage with asynchronous read and a down-counter that
// keeps the bank occupied for BUSY_CYC cycles after each accepted access.
module mem_bank
    import mem_resp_pkg::*;
#(
    parameter int DEPTH    = 8192,
    parameter int BUSY_CYC = 4,
    parameter int ROW_W    = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_i,
    input  logic              we_i,
    input  logic [ROW_W-1:0]  row_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o
);

    localparam int CNT_W = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Storage survives reset, so it has no reset branch at all.
    always_ff @(posedge clk) begin
        if (acc_i && we_i) begin
            mem_q[row_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[row_i];

    // The accept cycle itself counts as the first occupied cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (acc_i) begin
            cnt_d = CNT_W'(BUSY_CYC - 1);
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Occupancy counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != {CNT_W{1'b0}});

endmodule

// File: rtl/mem_bank_responder.sv
// Four-bank memory responder with per-bank occupancy and a fixed-latency read pipe.
// Optional request checking is enabled by defining MEM_RESP_ERR_CHECK_EN.
module mem_bank_responder
    import mem_resp_pkg::*;
#(
    parameter int BANK_DEPTH = 8192,
    parameter int RD_LAT     = 2,
    parameter int BANK_BUSY  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data_in,
    output logic [DATA_W-1:0]    data_out,
    output logic                 rd_valid,
    output logic                 stall,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 err
);

    localparam int ROW_W     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int ROW_SRC_W = ADDR_W - ROW_LSB;

    logic                 req_s;
    logic                 acc_s;
    logic                 acc_rd_s;
    logic                 we_s;
    bank_idx_t            bank_s;
    logic [ROW_SRC_W-1:0] row_src_s;
    logic [ROW_W-1:0]     row_s;
    logic [NUM_BANKS-1:0] bank_busy_s;
    logic [DATA_W-1:0]    bank_rdata_s [NUM_BANKS];
    rd_rec_t              pipe_q [RD_LAT];
    rd_rec_t              pipe_d [RD_LAT];
    logic [DATA_W-1:0]    data_out_q;
    logic [DATA_W-1:0]    data_out_d;

    assign req_s     = rd | wr;
    assign bank_s    = addr[BANK_MSB:BANK_LSB];
    assign row_src_s = addr[ADDR_W-1:ROW_LSB];
    assign row_s     = ROW_W'(32'(row_src_s) % BANK_DEPTH);

    // Stall looks only at registered occupancy, which keeps it free of loops through accept.
    assign stall = req_s & bank_busy_s[bank_s];

`ifdef MEM_RESP_ERR_CHECK_EN
    logic bad_s;
    logic err_q;
    logic err_d;

    assign bad_s = addr[0] | (rd & wr);
    assign acc_s = rst & req_s & ~stall & ~bad_s;
    assign we_s  = wr;

    // A malformed request is reported only when it would otherwise have been taken.
    always_comb begin
        err_d = rst & req_s & ~stall & bad_s;
    end

    // Error pulse register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_addr_lsb_s;

    assign unused_addr_lsb_s = addr[0];
    assign acc_s = rst & req_s & ~stall;
    assign we_s  = wr;
    assign err   = 1'b0;
`endif

    assign acc_rd_s = acc_s & ~we_s;
    assign busy     = bank_busy_s | (acc_s ? bank_onehot(bank_s) : {NUM_BANKS{1'b0}});

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .DEPTH    (BANK_DEPTH),
            .BUSY_CYC (BANK_BUSY),
            .ROW_W    (ROW_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst),
            .acc_i   (acc_s && (bank_s == BANK_W'(b))),
            .we_i    (we_s),
            .row_i   (row_s),
            .wdata_i (data_in),
            .rdata_o (bank_rdata_s[b]),
            .busy_o  (bank_busy_s[b])
        );
    end

    // Read data is captured at accept and shifted so results leave in accept order.
    always_comb begin
        pipe_d[0].valid = acc_rd_s;
        pipe_d[0].bank  = bank_s;
        pipe_d[0].data  = bank_rdata_s[bank_s];
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
        if (pipe_d[RD_LAT-1].valid) begin
            data_out_d = pipe_d[RD_LAT-1].data;
        end else begin
            data_out_d = data_out_q;
        end
    end

    // Read pipe and output data registers; reset drops every in-flight read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_q[k] <= rd_rec_t'({$bits(rd_rec_t){1'b0}});
            end
            data_out_q <= {DATA_W{1'b0}};
        end else begin
            pipe_q     <= pipe_d;
            data_out_q <= data_out_d;
        end
    end

    assign rd_valid = pipe_q[RD_LAT-1].valid;
    assign data_out = data_out_q;

endmodule
